// File: rtl/pri_enc_req_queue_pkg.sv
// Shared types and helpers for the pri_enc_req_queue priority encoder front end.
// N is limited to MAX_N lines by the onehot helper.
package pri_enc_pkg;

    localparam int unsigned MAX_N = 256;

    typedef enum logic {
        EDGE_LEVEL = 1'b0,
        EDGE_RISE  = 1'b1
    } edge_mode_e;

    // Width of an index into n lines; a single line still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot vector with bit idx set; empty when idx is out of range.
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        if (idx < n && idx < MAX_N) begin
            r = MAX_N'(1) << idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_enc_req_queue_if.sv
// Request/serve bus of pri_enc_req_queue. The mask line exists only when PRI_ENC_MASK_EN is defined.
interface pri_enc_req_queue_if #(
    parameter int unsigned N = 8
);
    import pri_enc_pkg::*;

    localparam int unsigned W = idx_w(N);

    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         any_pending;
`ifdef PRI_ENC_MASK_EN
    logic [N-1:0] mask;
`endif

    modport master (
        output req,
        output out_ready,
`ifdef PRI_ENC_MASK_EN
        output mask,
`endif
        input  out_valid,
        input  out_idx,
        input  any_pending
    );

    modport slave (
        input  req,
        input  out_ready,
`ifdef PRI_ENC_MASK_EN
        input  mask,
`endif
        output out_valid,
        output out_idx,
        output any_pending
    );

endinterface

// File: rtl/pri_enc_req_queue_enc.sv
// Combinational highest-index-wins encoder over an N-bit vector.
module pri_enc_n
    import pri_enc_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         hit_o
);

    // Ascending scan: later (higher) hits overwrite earlier ones.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_enc_req_queue.sv
// Sticky-pending priority encoder serving one request index per accept, highest index first.
// Optional per-line eligibility mask under PRI_ENC_MASK_EN.
module pri_enc_req_queue
    import pri_enc_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned EDGE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pri_enc_req_queue_if.slave   bus
);

    localparam int unsigned W = idx_w(N);

    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] req_d_q;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         any_pending_q, any_pending_d;

    logic [N-1:0] set_c;
    logic [N-1:0] clr_c;
    logic [N-1:0] elig_c;
    logic         accept_c;
    logic         load_c;
    logic [W-1:0] enc_idx_c;
    logic         enc_hit_c;

    assign accept_c = out_valid_q && bus.out_ready;
    assign load_c   = !out_valid_q || accept_c;

    // Set beats clear on the same bit, so a held level request re-pends as it is accepted.
    always_comb begin
        set_c = (EDGE == int'(EDGE_RISE)) ? (bus.req & ~req_d_q) : bus.req;
        clr_c = accept_c ? N'(onehot(int'(out_idx_q), N)) : '0;
        pending_d = (pending_q & ~clr_c) | set_c;
`ifdef PRI_ENC_MASK_EN
        elig_c = pending_d & ~bus.mask;
`else
        elig_c = pending_d;
`endif
    end

    pri_enc_n #(.N(N)) u_enc (
        .vec_i (elig_c),
        .idx_o (enc_idx_c),
        .hit_o (enc_hit_c)
    );

    // A presented index holds until accepted; no pre-emption by newer requests.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_idx_d     = out_idx_q;
        any_pending_d = |elig_c;
        if (load_c) begin
            out_valid_d = enc_hit_c;
            out_idx_d   = enc_hit_c ? enc_idx_c : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            req_d_q       <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= '0;
            any_pending_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            req_d_q       <= bus.req;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            any_pending_q <= any_pending_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.any_pending = any_pending_q;

endmodule
